axis_demux_1_2: RTL and testbench

Packet-aware 1-to-2 AXI-Stream demultiplexer. It is the counterpart of the 2-to-1 stream mux: a single slave stream is steered to one of two master streams. The `sel` input is sampled at the first beat of each packet and held until that packet's `tlast` beat is accepted. Each output has a one-deep register stage, and a 16-bit transferred-packet counter is kept per output.

---
 rtl/axis_if.sv | 15 +
 rtl/axis_demux_1_2.sv | 127 ++++++++++++
 tb/tb_axis_demux_1_2.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_if.sv
// AXI-Stream handshake bundle: tdata/tvalid/tlast forward, tready backward.
// Latency: none; this is a wiring bundle only.
// Backpressure: carried by tready, driven by the slave side of the link.
// Ports: master drives tdata/tvalid/tlast and samples tready; slave is the mirror.
interface axis_if #(
    parameter int DW = 8
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_demux_1_2.sv
// Packet-aware 1-to-2 AXI-Stream demux; sel is latched at packet start and held until tlast.
// Latency: one cycle through a one-deep register stage per output; 1 beat/cycle sustained.
// Backpressure: s.tready follows only the active output's register (combinational from its tready).
// Ports: clk, rst (async active-high), sel (0->m1, 1->m2), s (slave stream in),
//        m1/m2 (master streams out), m1_pkts/m2_pkts (16-bit wrapping tlast-transfer counts),
//        busy (packet open).
module axis_demux_1_2 #(
    parameter int DW = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    axis_if.slave       s,
    axis_if.master      m1,
    axis_if.master      m2,
    output logic [15:0] m1_pkts,
    output logic [15:0] m2_pkts,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT1 = 2'd1,
        PKT2 = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic            route;     // 0: m1, 1: m2
    logic            s_rdy;
    logic            accept;
    logic            load1;
    logic            load2;
    logic            drain1;
    logic            drain2;

    logic [DW-1:0]   m1_data_q;
    logic [DW-1:0]   m2_data_q;
    logic            m1_last_q;
    logic            m2_last_q;
    logic            m1_vld_q;
    logic            m2_vld_q;

    // Route, handshake and next-state. In IDLE the live sel steers the beat so a
    // single-beat packet needs no latched state; an open packet uses the latched route.
    always_comb begin
        route   = sel;
        state_d = state_q;
        case (state_q)
            PKT1:    route = 1'b0;
            PKT2:    route = 1'b1;
            default: route = sel;
        endcase

        // Only the destination register matters; the other output cannot stall us.
        s_rdy  = !rst && (route ? (!m2_vld_q || m2.tready) : (!m1_vld_q || m1.tready));
        accept = s.tvalid && s_rdy;
        load1  = accept && !route;
        load2  = accept && route;
        drain1 = m1_vld_q && m1.tready;
        drain2 = m2_vld_q && m2.tready;

        if (accept) begin
            case (state_q)
                IDLE:    if (!s.tlast) state_d = sel ? PKT2 : PKT1;
                default: if (s.tlast)  state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output registers: a load wins over a drain, so drain+load keeps valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m1_vld_q  <= 1'b0;
            m1_data_q <= '0;
            m1_last_q <= 1'b0;
            m2_vld_q  <= 1'b0;
            m2_data_q <= '0;
            m2_last_q <= 1'b0;
        end else begin
            if (load1) begin
                m1_vld_q  <= 1'b1;
                m1_data_q <= s.tdata;
                m1_last_q <= s.tlast;
            end else if (drain1) begin
                m1_vld_q  <= 1'b0;
            end
            if (load2) begin
                m2_vld_q  <= 1'b1;
                m2_data_q <= s.tdata;
                m2_last_q <= s.tlast;
            end else if (drain2) begin
                m2_vld_q  <= 1'b0;
            end
        end
    end

    // Packet counters count completed tlast transfers and wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m1_pkts <= 16'd0;
            m2_pkts <= 16'd0;
        end else begin
            if (drain1 && m1_last_q) m1_pkts <= m1_pkts + 16'd1;
            if (drain2 && m2_last_q) m2_pkts <= m2_pkts + 16'd1;
        end
    end

    assign s.tready  = s_rdy;
    assign m1.tvalid = m1_vld_q;
    assign m1.tdata  = m1_data_q;
    assign m1.tlast  = m1_last_q;
    assign m2.tvalid = m2_vld_q;
    assign m2.tdata  = m2_data_q;
    assign m2.tlast  = m2_last_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_axis_demux_1_2.sv
// Directed bench for axis_demux_1_2: reset, routing, sel hold, backpressure, mid-packet reset, counter wrap.
// Latency: inputs driven on the falling edge, registered outputs sampled 1 time unit after the rising edge.
// Backpressure: sink readies are driven directly per scenario.
module tb_axis_demux_1_2;

    logic        clk;
    logic        rst;
    logic        sel;
    logic [15:0] m1_pkts;
    logic [15:0] m2_pkts;
    logic        busy;

    int checks;
    int errors;

    axis_if #(.DW(8)) s_if ();
    axis_if #(.DW(8)) m1_if ();
    axis_if #(.DW(8)) m2_if ();

    axis_demux_1_2 #(.DW(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .sel     (sel),
        .s       (s_if.slave),
        .m1      (m1_if.master),
        .m2      (m2_if.master),
        .m1_pkts (m1_pkts),
        .m2_pkts (m2_pkts),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        sel = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = 8'h00;
        s_if.tlast  = 1'b0;
        m1_if.tready = 1'b1;
        m2_if.tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({s_if.tready, m1_if.tvalid, m2_if.tvalid, m1_if.tlast, m2_if.tlast, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy=%b v1=%b v2=%b l1=%b l2=%b busy=%b, want all 0",
                     s_if.tready, m1_if.tvalid, m2_if.tvalid, m1_if.tlast, m2_if.tlast, busy);
        end
        checks++;
        if ({m1_if.tdata, m2_if.tdata, m1_pkts, m2_pkts} !== 48'h0) begin
            errors++;
            $display("FAIL reset_data: got d1=%h d2=%h p1=%h p2=%h, want 0",
                     m1_if.tdata, m2_if.tdata, m1_pkts, m2_pkts);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (s_if.tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_rdy: got %b want 1", s_if.tready);
        end
    endtask

    task automatic test_route_m1();
        logic [7:0] exp_d;
        sel = 1'b0;
        m1_if.tready = 1'b1;
        m2_if.tready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_d = 8'(2 * (i + 1));
            @(negedge clk);
            s_if.tvalid = 1'b1;
            s_if.tdata  = exp_d;
            s_if.tlast  = (i == 9);
            #1;
            checks++;
            if (s_if.tready !== 1'b1) begin
                errors++;
                $display("FAIL route_m1_rdy beat %0d: got %b want 1", i, s_if.tready);
            end
            @(posedge clk);
            #1;
            checks++;
            if (m1_if.tvalid !== 1'b1 || m1_if.tdata !== exp_d || m1_if.tlast !== (i == 9)) begin
                errors++;
                $display("FAIL route_m1_out beat %0d: got v=%b d=%0d l=%b want v=1 d=%0d l=%b",
                         i, m1_if.tvalid, m1_if.tdata, m1_if.tlast, exp_d, (i == 9));
            end
            checks++;
            if (m2_if.tvalid !== 1'b0) begin
                errors++;
                $display("FAIL route_m1_m2idle beat %0d: got m2_tvalid=%b want 0", i, m2_if.tvalid);
            end
            checks++;
            if (busy !== (i != 9)) begin
                errors++;
                $display("FAIL route_m1_busy beat %0d: got %b want %b", i, busy, (i != 9));
            end
        end
        @(negedge clk);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (m1_pkts !== 16'd1 || m1_if.tvalid !== 1'b0 || m2_pkts !== 16'd0) begin
            errors++;
            $display("FAIL route_m1_pkts: got p1=%0d v1=%b p2=%0d want p1=1 v1=0 p2=0",
                     m1_pkts, m1_if.tvalid, m2_pkts);
        end
    endtask

    task automatic test_sel_change();
        logic [7:0] exp_d;
        sel = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_d = 8'h30 + 8'(i);
            @(negedge clk);
            if (i == 3) sel = 1'b1;
            s_if.tvalid = 1'b1;
            s_if.tdata  = exp_d;
            s_if.tlast  = (i == 7);
            @(posedge clk);
            #1;
            checks++;
            if (m1_if.tvalid !== 1'b1 || m1_if.tdata !== exp_d || m2_if.tvalid !== 1'b0) begin
                errors++;
                $display("FAIL selchg_m1 beat %0d: got v1=%b d1=%h v2=%b want v1=1 d1=%h v2=0",
                         i, m1_if.tvalid, m1_if.tdata, m2_if.tvalid, exp_d);
            end
        end
        // Second packet immediately follows; sel is still 1.
        for (int i = 0; i < 3; i++) begin
            exp_d = 8'h40 + 8'(i);
            @(negedge clk);
            s_if.tvalid = 1'b1;
            s_if.tdata  = exp_d;
            s_if.tlast  = (i == 2);
            #1;
            if (i == 0) begin
                checks++;
                if (s_if.tready !== 1'b1) begin
                    errors++;
                    $display("FAIL selchg_nobubble: got s_tready=%b want 1", s_if.tready);
                end
            end
            @(posedge clk);
            #1;
            checks++;
            if (m2_if.tvalid !== 1'b1 || m2_if.tdata !== exp_d || m1_if.tvalid !== 1'b0) begin
                errors++;
                $display("FAIL selchg_m2 beat %0d: got v2=%b d2=%h v1=%b want v2=1 d2=%h v1=0",
                         i, m2_if.tvalid, m2_if.tdata, m1_if.tvalid, exp_d);
            end
        end
        @(negedge clk);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (m1_pkts !== 16'd2 || m2_pkts !== 16'd1) begin
            errors++;
            $display("FAIL selchg_pkts: got p1=%0d p2=%0d want p1=2 p2=1", m1_pkts, m2_pkts);
        end
    endtask

    task automatic test_backpressure();
        sel = 1'b1;
        m1_if.tready = 1'b0;
        m2_if.tready = 1'b0;
        @(negedge clk);
        s_if.tvalid = 1'b1;
        s_if.tdata  = 8'h51;
        s_if.tlast  = 1'b0;
        #1;
        checks++;
        if (s_if.tready !== 1'b1) begin
            errors++;
            $display("FAIL bp_m1_ignored: got s_tready=%b want 1", s_if.tready);
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            s_if.tdata = 8'h52;
            #1;
            checks++;
            if (s_if.tready !== 1'b0 || m2_if.tvalid !== 1'b1 || m2_if.tdata !== 8'h51) begin
                errors++;
                $display("FAIL bp_hold cyc %0d: got rdy=%b v2=%b d2=%h want rdy=0 v2=1 d2=51",
                         k, s_if.tready, m2_if.tvalid, m2_if.tdata);
            end
            @(posedge clk);
        end
        @(negedge clk);
        m2_if.tready = 1'b1;
        #1;
        checks++;
        if (s_if.tready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_rdy: got %b want 1", s_if.tready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (m2_if.tvalid !== 1'b1 || m2_if.tdata !== 8'h52) begin
            errors++;
            $display("FAIL bp_resume_b: got v2=%b d2=%h want v2=1 d2=52", m2_if.tvalid, m2_if.tdata);
        end
        @(negedge clk);
        s_if.tdata = 8'h53;
        s_if.tlast = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (m2_if.tvalid !== 1'b1 || m2_if.tdata !== 8'h53 || m2_if.tlast !== 1'b1 || m1_if.tvalid !== 1'b0) begin
            errors++;
            $display("FAIL bp_resume_c: got v2=%b d2=%h l2=%b v1=%b want v2=1 d2=53 l2=1 v1=0",
                     m2_if.tvalid, m2_if.tdata, m2_if.tlast, m1_if.tvalid);
        end
        @(negedge clk);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (m2_pkts !== 16'd2 || m2_if.tvalid !== 1'b0 || m1_pkts !== 16'd2) begin
            errors++;
            $display("FAIL bp_pkts: got p2=%0d v2=%b p1=%0d want p2=2 v2=0 p1=2",
                     m2_pkts, m2_if.tvalid, m1_pkts);
        end
        m1_if.tready = 1'b1;
    endtask

    task automatic test_reset_mid();
        sel = 1'b1;
        m1_if.tready = 1'b1;
        m2_if.tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            s_if.tvalid = 1'b1;
            s_if.tdata  = 8'h60 + 8'(i);
            s_if.tlast  = 1'b0;
            @(posedge clk);
        end
        #1;
        checks++;
        if (m2_if.tvalid !== 1'b1 || m2_if.tdata !== 8'h64 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: got v2=%b d2=%h busy=%b want v2=1 d2=64 busy=1",
                     m2_if.tvalid, m2_if.tdata, busy);
        end
        #1;
        rst = 1'b1;
        s_if.tvalid = 1'b0;
        #1;
        checks++;
        if (m2_if.tvalid !== 1'b0 || busy !== 1'b0 || m1_pkts !== 16'd0 || m2_pkts !== 16'd0
            || s_if.tready !== 1'b0 || m2_if.tdata !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_clear: got v2=%b busy=%b p1=%0d p2=%0d rdy=%b d2=%h want all 0",
                     m2_if.tvalid, busy, m1_pkts, m2_pkts, s_if.tready, m2_if.tdata);
        end
        @(negedge clk);
        rst = 1'b0;
        sel = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            s_if.tvalid = 1'b1;
            s_if.tdata  = 8'h71 + 8'(i);
            s_if.tlast  = (i == 1);
            @(posedge clk);
            #1;
            checks++;
            if (m1_if.tvalid !== 1'b1 || m1_if.tdata !== 8'h71 + 8'(i) || m2_if.tvalid !== 1'b0
                || busy !== (i == 0)) begin
                errors++;
                $display("FAIL rstmid_m1 beat %0d: got v1=%b d1=%h v2=%b busy=%b want v1=1 d1=%h v2=0 busy=%b",
                         i, m1_if.tvalid, m1_if.tdata, m2_if.tvalid, busy, 8'h71 + 8'(i), (i == 0));
            end
        end
        @(negedge clk);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (m1_pkts !== 16'd1 || m2_pkts !== 16'd0) begin
            errors++;
            $display("FAIL rstmid_pkts: got p1=%0d p2=%0d want p1=1 p2=0", m1_pkts, m2_pkts);
        end
    endtask

    task automatic test_counter_wrap();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sel = 1'b0;
        m1_if.tready = 1'b1;
        m2_if.tready = 1'b1;
        s_if.tvalid = 1'b1;
        s_if.tdata  = 8'hA5;
        s_if.tlast  = 1'b1;
        repeat (65536) @(posedge clk);
        #1;
        // 65536 beats accepted, 65535 of them already transferred.
        checks++;
        if (m1_pkts !== 16'hFFFF || busy !== 1'b0) begin
            errors++;
            $display("FAIL wrap_ffff: got p1=%h busy=%b want p1=ffff busy=0", m1_pkts, busy);
        end
        @(negedge clk);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (m1_pkts !== 16'h0000 || m2_pkts !== 16'h0000 || m1_if.tvalid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_zero: got p1=%h p2=%h v1=%b want p1=0000 p2=0000 v1=0",
                     m1_pkts, m2_pkts, m1_if.tvalid);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_route_m1();
        test_sel_change();
        test_backpressure();
        test_reset_mid();
        test_counter_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
